b02_seq_ctrl: RTL and testbench

- Sequencing controller for the b02 serial-line recogniser. It owns the 3-bit STATO state register and the U output register that sit around the combinational b02_C next-state core.
- It feeds the core a programmable LINEA bit pattern, one bit per clock, and counts recognitions.
- It provides a 3-bit scan path so the bench and the DFT flow can preload and unload STATO.
- The core is instantiated externally; this block only drives its inputs and registers its outputs.

---
 rtl/b02_seq_ctrl.sv | 85 ++++++++
 tb/tb_b02_seq_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/b02_seq_ctrl.sv
// b02_seq_ctrl: sequencing controller around the external b02 core.
// Feeds LINEA patterns, owns the STATO/U registers, counts hits and scans STATO.
module b02_seq_ctrl #(
    parameter int PAT_W = 32,
    parameter int LEN_W = 6,
    parameter int CNT_W = 16
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_pat_len,
    input  logic [PAT_W-1:0] i_pat_data,
    input  logic             i_scan_en,
    input  logic             i_scan_in,
    output logic             o_scan_out,
    output logic             o_core_linea,
    output logic [2:0]       o_core_stato_in,
    input  logic [2:0]       i_core_stato_nxt,
    input  logic             i_core_u_nxt,
    output logic             o_u_out,
    output logic [2:0]       o_state_out,
    output logic [CNT_W-1:0] o_hit_count,
    output logic             o_busy,
    output logic             o_done
);
    typedef enum logic [1:0] {IDLE, RUN, SCAN, FIN} state_t;
    localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);
    state_t           r_state, w_state_nxt;
    logic [2:0]       r_stato;
    logic             r_u;
    logic [PAT_W-1:0] r_shift;
    logic [LEN_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hits;
    logic             w_len_zero, w_accept, w_scan_shift;
    assign w_len_zero   = i_pat_len == '0;
    assign w_accept     = r_state == IDLE && !i_scan_en && i_start;
    // The entry edge from IDLE already shifts, so N scan cycles load N bits.
    assign w_scan_shift = i_scan_en && (r_state == IDLE || r_state == SCAN);
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = i_scan_en ? SCAN : i_start ? (w_len_zero ? FIN : RUN) : IDLE;
            RUN:     w_state_nxt = r_cnt == LEN_W'(1) ? FIN : RUN;
            SCAN:    w_state_nxt = i_scan_en ? SCAN : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_stato <= '0;
            r_u     <= 1'b0;
            r_shift <= '0;
            r_cnt   <= '0;
            r_hits  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_hits <= '0;
                if (!w_len_zero) begin
                    r_shift <= i_pat_data;
                    r_cnt   <= i_pat_len > PAT_W_L ? PAT_W_L : i_pat_len;
                end
            end
            if (r_state == RUN) begin
                r_stato <= i_core_stato_nxt;
                r_u     <= i_core_u_nxt;
                r_shift <= r_shift >> 1;
                r_cnt   <= r_cnt - LEN_W'(1);
                if (i_core_u_nxt && !(&r_hits))
                    r_hits <= r_hits + CNT_W'(1);
            end
            if (w_scan_shift)
                r_stato <= {i_scan_in, r_stato[2:1]};
        end
    end
    assign o_scan_out      = r_stato[0];
    assign o_core_linea    = r_state == RUN ? r_shift[0] : 1'b0;
    assign o_core_stato_in = r_stato;
    assign o_u_out         = r_u;
    assign o_state_out     = r_stato;
    assign o_hit_count     = r_hits;
    assign o_busy          = r_state == RUN || r_state == SCAN;
    assign o_done          = r_state == FIN;
endmodule

// File: tb/tb_b02_seq_ctrl.sv
// tb_b02_seq_ctrl: randomized and directed checks of b02_seq_ctrl against a bit-level run model.
// Two instances share stimulus; the second has a 2-bit hit counter to expose saturation.
module tb_b02_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst, start, scan_en, scan_in;
    logic [5:0]  pat_len;
    logic [31:0] pat_data;
    logic        a_scan_out, a_linea, a_u, a_busy, a_done, a_unxt;
    logic [2:0]  a_stato_in, a_state, a_nxt;
    logic [15:0] a_hits;
    logic        b_scan_out, b_linea, b_u, b_busy, b_done, b_unxt;
    logic [2:0]  b_stato_in, b_state, b_nxt;
    logic [1:0]  b_hits;
    int          n_chk = 0, n_fail = 0;
    logic [2:0]  exp_seq [5] = '{3'b001, 3'b101, 3'b110, 3'b100, 3'b001};
    logic [2:0]  ms;
    logic        mu;

    always #5 clk = ~clk;

    // Core reference; 011 and 111 are unspecified, chosen to close the all-zero loop through 100.
    function automatic logic [2:0] core_nxt(input logic [2:0] s, input logic l);
        case (s)
            3'b000:  return 3'b001;
            3'b001:  return l ? 3'b101 : 3'b010;
            3'b101:  return 3'b110;
            3'b110:  return l ? 3'b000 : 3'b100;
            3'b100:  return 3'b001;
            3'b010:  return l ? 3'b110 : 3'b011;
            3'b011:  return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    assign a_nxt  = core_nxt(a_stato_in, a_linea);
    assign a_unxt = a_stato_in == 3'b100;
    assign b_nxt  = core_nxt(b_stato_in, b_linea);
    assign b_unxt = b_stato_in == 3'b100;

    b02_seq_ctrl #(.PAT_W(32), .LEN_W(6), .CNT_W(16)) dut_a (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_pat_len(pat_len), .i_pat_data(pat_data),
        .i_scan_en(scan_en), .i_scan_in(scan_in), .o_scan_out(a_scan_out), .o_core_linea(a_linea),
        .o_core_stato_in(a_stato_in), .i_core_stato_nxt(a_nxt), .i_core_u_nxt(a_unxt), .o_u_out(a_u),
        .o_state_out(a_state), .o_hit_count(a_hits), .o_busy(a_busy), .o_done(a_done));

    b02_seq_ctrl #(.PAT_W(32), .LEN_W(6), .CNT_W(2)) dut_b (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_pat_len(pat_len), .i_pat_data(pat_data),
        .i_scan_en(scan_en), .i_scan_in(scan_in), .o_scan_out(b_scan_out), .o_core_linea(b_linea),
        .o_core_stato_in(b_stato_in), .i_core_stato_nxt(b_nxt), .i_core_u_nxt(b_unxt), .o_u_out(b_u),
        .o_state_out(b_state), .o_hit_count(b_hits), .o_busy(b_busy), .o_done(b_done));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Whole-run model: walk the applied bits through the core reference.
    task automatic model_run(input logic [2:0] s0, input logic u0, input logic [31:0] d, input int len,
                             input int cmax, output logic [2:0] s, output logic u, output int h, output int n);
        n = len > 32 ? 32 : len;
        s = s0;
        u = u0;
        h = 0;
        for (int i = 0; i < n; i++) begin
            u = s == 3'b100;
            if (u && h < cmax) h++;
            s = core_nxt(s, d[i]);
        end
    endtask

    task automatic scan3(input logic [2:0] v, output logic [2:0] outs);
        scan_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            scan_in = v[i];
            outs[i] = a_scan_out;
            tick;
        end
        scan_en = 1'b0;
        scan_in = 1'b0;
        tick;
    endtask

    task automatic do_run(input logic [31:0] d, input logic [5:0] len, input bit poke,
                          output int cyc, output logic done_seen);
        pat_data = d;
        pat_len  = len;
        start    = 1'b1;
        tick;
        start = 1'b0;
        cyc   = 0;
        while (a_busy && cyc < 100) begin
            if (poke) start = 1'($urandom_range(0, 1));
            cyc++;
            tick;
        end
        start     = 1'b0;
        done_seen = a_done;
        tick;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        n_chk++; if (a_state !== 3'b000) begin n_fail++; $display("FAIL reset_stato got %b want 000", a_state); end
        n_chk++; if (a_u !== 1'b0) begin n_fail++; $display("FAIL reset_u got %b want 0", a_u); end
        n_chk++; if (a_hits !== 16'd0) begin n_fail++; $display("FAIL reset_hits got %0d want 0", a_hits); end
        n_chk++; if ({a_busy, a_done, a_linea, a_scan_out} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got %b want 0000", {a_busy, a_done, a_linea, a_scan_out}); end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_recognition;
        pat_data = 32'h0000_0002;
        pat_len  = 6'd5;
        start    = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_chk++; if (a_busy !== 1'b1 || a_done !== 1'b0) begin n_fail++; $display("FAIL rec_busy cycle %0d got busy=%b done=%b want 1/0", i + 1, a_busy, a_done); end
            n_chk++; if (a_linea !== pat_data[i]) begin n_fail++; $display("FAIL rec_linea cycle %0d got %b want %b", i + 1, a_linea, pat_data[i]); end
            tick;
            n_chk++; if (a_state !== exp_seq[i]) begin n_fail++; $display("FAIL rec_stato edge %0d got %b want %b", i + 1, a_state, exp_seq[i]); end
        end
        n_chk++; if (a_done !== 1'b1 || a_busy !== 1'b0) begin n_fail++; $display("FAIL rec_done got done=%b busy=%b want 1/0", a_done, a_busy); end
        n_chk++; if (a_u !== 1'b1 || a_hits !== 16'd1) begin n_fail++; $display("FAIL rec_hit got u=%b hits=%0d want 1/1", a_u, a_hits); end
        tick;
        n_chk++; if (a_done !== 1'b0 || a_hits !== 16'd1) begin n_fail++; $display("FAIL rec_after got done=%b hits=%0d want 0/1", a_done, a_hits); end
    endtask

    task automatic test_scan;
        logic [2:0] outs;
        int         cyc;
        logic       dn;
        scan3(3'b100, outs);
        n_chk++; if (a_state !== 3'b100) begin n_fail++; $display("FAIL scan_load got %b want 100", a_state); end
        do_run(32'h0, 6'd1, 1'b0, cyc, dn);
        n_chk++; if (a_state !== 3'b001 || a_u !== 1'b1 || a_hits !== 16'd1 || cyc != 1) begin n_fail++; $display("FAIL scan_run got stato=%b u=%b hits=%0d cyc=%0d want 001/1/1/1", a_state, a_u, a_hits, cyc); end
        scan3(3'b000, outs);
        n_chk++; if (outs !== 3'b001) begin n_fail++; $display("FAIL scan_unload got %b want 001 (first bit in lsb)", outs); end
        n_chk++; if (a_state !== 3'b000 || a_hits !== 16'd1 || a_u !== 1'b1) begin n_fail++; $display("FAIL scan_hold got stato=%b hits=%0d u=%b want 000/1/1", a_state, a_hits, a_u); end
    endtask

    task automatic test_zero_priority;
        logic [2:0] outs;
        scan3(3'b110, outs);
        pat_len = 6'd0;
        start   = 1'b1;
        tick;
        start = 1'b0;
        n_chk++; if (a_done !== 1'b1 || a_busy !== 1'b0) begin n_fail++; $display("FAIL zero_done got done=%b busy=%b want 1/0", a_done, a_busy); end
        n_chk++; if (a_state !== 3'b110 || a_hits !== 16'd0 || a_u !== 1'b1) begin n_fail++; $display("FAIL zero_hold got stato=%b hits=%0d u=%b want 110/0/1", a_state, a_hits, a_u); end
        tick;
        pat_len = 6'd5;
        start   = 1'b1;
        scan_en = 1'b1;
        scan_in = 1'b1;
        tick;
        start   = 1'b0;
        scan_en = 1'b0;
        n_chk++; if (a_state !== 3'b111 || a_busy !== 1'b1 || a_linea !== 1'b0) begin n_fail++; $display("FAIL prio_scan got stato=%b busy=%b linea=%b want 111/1/0", a_state, a_busy, a_linea); end
        tick;
        n_chk++; if (a_busy !== 1'b0 || a_done !== 1'b0 || a_state !== 3'b111) begin n_fail++; $display("FAIL prio_norun got busy=%b done=%b stato=%b want 0/0/111", a_busy, a_done, a_state); end
        scan_in = 1'b0;
    endtask

    task automatic test_ignore_start;
        int   cyc;
        logic dn;
        do_run($urandom, 6'd7, 1'b1, cyc, dn);
        n_chk++; if (cyc != 7 || dn !== 1'b1) begin n_fail++; $display("FAIL ignore_start got cyc=%0d done=%b want 7/1", cyc, dn); end
    endtask

    task automatic test_clip;
        int   cyc;
        logic dn;
        logic [5:0] lens [3] = '{6'd63, 6'd33, 6'd32};
        for (int i = 0; i < 3; i++) begin
            do_run($urandom, lens[i], 1'b0, cyc, dn);
            n_chk++; if (cyc != 32 || dn !== 1'b1) begin n_fail++; $display("FAIL clip len=%0d got cyc=%0d done=%b want 32/1", lens[i], cyc, dn); end
        end
    endtask

    task automatic test_saturation;
        logic [2:0] outs;
        int         cyc;
        logic       dn;
        scan3(3'b100, outs);
        do_run(32'h0, 6'd32, 1'b0, cyc, dn);
        n_chk++; if (a_hits !== 16'd8) begin n_fail++; $display("FAIL sat_wide got %0d want 8", a_hits); end
        n_chk++; if (b_hits !== 2'd3) begin n_fail++; $display("FAIL sat_narrow got %0d want 3", b_hits); end
        n_chk++; if (a_state !== 3'b100 || a_u !== 1'b0) begin n_fail++; $display("FAIL sat_end got stato=%b u=%b want 100/0", a_state, a_u); end
    endtask

    task automatic test_reset_mid_run;
        logic [2:0] outs;
        scan3(3'b000, outs);
        pat_data = 32'h2222_2222;
        pat_len  = 6'd20;
        start    = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick;
        n_chk++; if (a_busy !== 1'b1 || a_hits !== 16'd1) begin n_fail++; $display("FAIL midrun_pre got busy=%b hits=%0d want 1/1", a_busy, a_hits); end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n_chk++; if (a_state !== 3'b000 || a_u !== 1'b0 || a_hits !== 16'd0 || a_busy !== 1'b0) begin n_fail++; $display("FAIL midrun_reset got stato=%b u=%b hits=%0d busy=%b want 000/0/0/0", a_state, a_u, a_hits, a_busy); end
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (a_done !== 1'b0 || a_busy !== 1'b0) begin n_fail++; $display("FAIL midrun_nodone cycle %0d got done=%b busy=%b want 0/0", i, a_done, a_busy); end
            tick;
        end
    endtask

    task automatic test_random;
        logic [2:0]  outs, es;
        logic        eu, dn;
        logic [31:0] d;
        logic [5:0]  len;
        int          eh, ehb, en, cyc;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        ms = 3'b000;
        mu = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                ms = 3'($urandom_range(0, 7));
                scan3(ms, outs);
            end
            d   = $urandom;
            len = 6'($urandom_range(0, 63));
            model_run(ms, mu, d, int'(len), 65535, es, eu, eh, en);
            model_run(ms, mu, d, int'(len), 3, es, eu, ehb, en);
            do_run(d, len, 1'b1, cyc, dn);
            n_chk++; if (a_state !== es || a_u !== eu || cyc != en || dn !== 1'b1) begin n_fail++; $display("FAIL rand_run %0d len=%0d got stato=%b u=%b cyc=%0d done=%b want %b/%b/%0d/1", k, len, a_state, a_u, cyc, dn, es, eu, en); end
            n_chk++; if (a_hits !== 16'(eh) || b_hits !== 2'(ehb)) begin n_fail++; $display("FAIL rand_hits %0d got %0d/%0d want %0d/%0d", k, a_hits, b_hits, eh, ehb); end
            ms = es;
            mu = eu;
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        scan_en  = 1'b0;
        scan_in  = 1'b0;
        pat_len  = '0;
        pat_data = '0;
        test_reset;
        test_recognition;
        test_scan;
        test_zero_priority;
        test_ignore_start;
        test_clip;
        test_saturation;
        test_reset_mid_run;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout reached at %0t", $time);
        $fatal(1, "timeout");
    end
endmodule
